// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying one pipeline entry (payload plus
// register-file write-enable). The producer side uses the master modport
// and the consumer side uses the slave modport.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 128
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              wen;

  modport master (output valid, output data, output wen, input ready);
  modport slave  (input valid, input data, input wen, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage. The main register drives the
// downstream channel and the skid register absorbs the one extra entry that
// can arrive while in_ready is still registered high. The upstream ready is
// fully registered, so there is no combinational path from out_ready back to
// in_ready. A flush squashes every held entry; a saturating counter records
// the cycles in which the downstream consumer stalls a valid entry.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  in_ch,
  pipe_stage_skid_if.master out_ch,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_wen_q, main_wen_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_wen_q, skid_wen_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic accept;
  logic out_valid;

  assign out_valid    = (state_q != ST_EMPTY);
  assign accept       = in_ch.valid & in_ready_q;

  assign in_ch.ready  = in_ready_q;
  assign out_ch.valid = out_valid;
  assign out_ch.data  = main_data_q;
  assign out_ch.wen   = main_wen_q & out_valid;
  assign occupancy    = state_q;
  assign stall_cnt    = stall_cnt_q;

  // Next-state and register-move decisions; flush overrides every transition
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_wen_d  = main_wen_q;
    skid_data_d = skid_data_q;
    skid_wen_d  = skid_wen_q;

    if (flush) begin
      state_d    = ST_EMPTY;
      main_wen_d = 1'b0;
      skid_wen_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = in_ch.data;
            main_wen_d  = in_ch.wen;
          end
        end
        ST_ONE: begin
          if (accept && out_ch.ready) begin
            main_data_d = in_ch.data;
            main_wen_d  = in_ch.wen;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_data_d = in_ch.data;
            skid_wen_d  = in_ch.wen;
          end else if (out_ch.ready) begin
            state_d    = ST_EMPTY;
            main_wen_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (out_ch.ready) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_wen_d  = skid_wen_q;
            skid_wen_d  = 1'b0;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_wen_d = 1'b0;
          skid_wen_d = 1'b0;
        end
      endcase
    end

    in_ready_d = (state_d != ST_TWO);
  end

  // Stall counter saturates at all-ones and keeps counting through flushes
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ch.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and storage registers; reset empties the stage and holds off upstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_wen_q  <= 1'b0;
      skid_data_q <= '0;
      skid_wen_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_wen_q  <= main_wen_d;
      skid_data_q <= skid_data_d;
      skid_wen_q  <= skid_wen_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (16-bit and 4-bit stall counter)
// share stimulus; a two-deep FIFO reference model predicts every output.
module tb_pipe_stage_skid;
  localparam int DW = 128;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW)) in1 ();
  pipe_stage_skid_if #(.DATA_W(DW)) out1 ();
  pipe_stage_skid_if #(.DATA_W(DW)) in2 ();
  pipe_stage_skid_if #(.DATA_W(DW)) out2 ();

  logic [1:0]  occ1, occ2;
  logic [15:0] stall1;
  logic [3:0]  stall2;

  assign in2.valid  = in1.valid;
  assign in2.data   = in1.data;
  assign in2.wen    = in1.wen;
  assign out2.ready = out1.ready;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_ch(in1), .out_ch(out1),
    .occupancy(occ1), .stall_cnt(stall1));

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_ch(in2), .out_ch(out2),
    .occupancy(occ2), .stall_cnt(stall2));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ordered list of held entries {wen, data}, at most two deep
  logic [DW:0] mq[$];
  bit          m_in_ready;
  int          m_stall16;
  int          m_stall4;

  task automatic model_reset();
    mq.delete();
    m_in_ready = 1'b0;
    m_stall16  = 0;
    m_stall4   = 0;
  endtask

  // One clock: model decisions use pre-edge inputs, outputs are sampled 1ns later
  task automatic tick();
    bit          acc, pop, stl;
    logic [DW:0] ent;
    acc = in1.valid && m_in_ready;
    pop = (mq.size() != 0) && out1.ready;
    stl = (mq.size() != 0) && !out1.ready;
    ent = {in1.wen, in1.data};
    @(posedge clk);
    if (stl) begin
      if (m_stall16 < 65535) m_stall16++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(ent);
    end
    m_in_ready = (mq.size() < 2);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    in1.valid = 1'b0;
    flush = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic drain();
    in1.valid  = 1'b0;
    flush      = 1'b0;
    out1.ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    in1.valid = 1'b0; in1.data = '0; in1.wen = 1'b0; out1.ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out1.valid, out1.wen, occ1, stall1, in1.ready} !== 21'd0) begin
      n_err++; $display("[TB] FAIL reset_dut1 got=%h exp=0", {out1.valid, out1.wen, occ1, stall1, in1.ready});
    end
    n_cmp++;
    if ({out2.valid, out2.wen, occ2, stall2, in2.ready} !== 9'd0) begin
      n_err++; $display("[TB] FAIL reset_dut2 got=%h exp=0", {out2.valid, out2.wen, occ2, stall2, in2.ready});
    end
    n_cmp++;
    if (out1.data !== '0) begin
      n_err++; $display("[TB] FAIL reset_data got=%h exp=0", out1.data);
    end
    model_reset();
    in1.valid = 1'b1; in1.data = 128'h55; in1.wen = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out1.valid, occ1, in1.ready} !== 4'd0) begin
      n_err++; $display("[TB] FAIL reset_no_accept got=%b exp=0000", {out1.valid, occ1, in1.ready});
    end
    in1.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (in1.ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_release_ready got=%b exp=1", in1.ready);
    end
  endtask

  task automatic test_single();
    in1.valid = 1'b1; in1.data = 128'hA; in1.wen = 1'b1; out1.ready = 1'b1;
    tick();
    in1.valid = 1'b0;
    n_cmp++;
    if ({out1.valid, out1.wen, occ1} !== 4'b1101 || out1.data !== 128'hA) begin
      n_err++; $display("[TB] FAIL single got v/w/occ=%b data=%h exp=1101 data=a", {out1.valid, out1.wen, occ1}, out1.data);
    end
  endtask

  task automatic test_stream();
    drain();
    in1.valid = 1'b1; in1.wen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in1.data = 128'(i);
      tick();
      n_cmp++;
      if (out1.valid !== 1'b1 || out1.data !== 128'(i) || out1.wen !== 1'b0) begin
        n_err++; $display("[TB] FAIL stream_%0d got v=%b d=%h w=%b exp v=1 d=%0h w=0", i, out1.valid, out1.data, out1.wen, i);
      end
    end
    in1.valid = 1'b0;
    n_cmp++;
    if (stall1 !== 16'd0) begin
      n_err++; $display("[TB] FAIL stream_stall got=%0d exp=0", stall1);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] seen[$];
    bit took;
    drain();
    out1.ready = 1'b0; in1.valid = 1'b1; in1.wen = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in1.data = 128'(i);
      tick();
    end
    n_cmp++;
    if ({in1.ready, occ1, out1.valid} !== 4'b0101 || out1.data !== 128'h1) begin
      n_err++; $display("[TB] FAIL bp_full got rdy/occ/v=%b data=%h exp=0101 data=1", {in1.ready, occ1, out1.valid}, out1.data);
    end
    out1.ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out1.valid) seen.push_back(out1.data);
      took = in1.valid && in1.ready;
      tick();
      if (took) in1.valid = 1'b0;
    end
    n_cmp++;
    if (seen.size() != 3) begin
      n_err++; $display("[TB] FAIL bp_count got=%0d exp=3", seen.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seen[k] !== 128'(k + 1)) begin
          n_err++; $display("[TB] FAIL bp_order_%0d got=%h exp=%0h", k, seen[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_flush();
    drain();
    out1.ready = 1'b0; in1.valid = 1'b1; in1.wen = 1'b1;
    in1.data = 128'h5; tick();
    in1.data = 128'h6; tick();
    n_cmp++;
    if (occ1 !== 2'd2) begin
      n_err++; $display("[TB] FAIL flush_pre_occ got=%0d exp=2", occ1);
    end
    flush = 1'b1; in1.data = 128'h9;
    tick();
    flush = 1'b0; in1.valid = 1'b0;
    n_cmp++;
    if ({out1.valid, out1.wen, occ1, in1.ready} !== 5'b00001) begin
      n_err++; $display("[TB] FAIL flush_post got v/w/occ/rdy=%b exp=00001", {out1.valid, out1.wen, occ1, in1.ready});
    end
    out1.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out1.valid !== 1'b0 || out1.wen !== 1'b0) begin
        n_err++; $display("[TB] FAIL flush_leak_%0d got v=%b d=%h exp v=0", i, out1.valid, out1.data);
      end
    end
  endtask

  task automatic test_stall_sat();
    apply_reset();
    out1.ready = 1'b0; in1.valid = 1'b1; in1.data = 128'h7; in1.wen = 1'b1;
    tick();
    in1.valid = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 10 || i == 20 || i == 25) begin
        n_cmp++;
        if (stall2 !== 4'((i > 15) ? 15 : i)) begin
          n_err++; $display("[TB] FAIL stall4_%0d got=%0d exp=%0d", i, stall2, (i > 15) ? 15 : i);
        end
        n_cmp++;
        if (stall1 !== 16'(i)) begin
          n_err++; $display("[TB] FAIL stall16_%0d got=%0d exp=%0d", i, stall1, i);
        end
      end
    end
    n_cmp++;
    if (out1.valid !== 1'b1 || out1.data !== 128'h7 || out1.wen !== 1'b1) begin
      n_err++; $display("[TB] FAIL stall_hold got v=%b d=%h w=%b exp v=1 d=7 w=1", out1.valid, out1.data, out1.wen);
    end
  endtask

  task automatic test_random();
    bit          ev, ew;
    logic [DW:0] head;
    for (int c = 0; c < 3000; c++) begin
      in1.valid  = ($urandom_range(0, 3) != 0);
      in1.data   = {$urandom, $urandom, $urandom, $urandom};
      in1.wen    = 1'($urandom_range(0, 1));
      out1.ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      tick();
      ev   = (mq.size() != 0);
      head = ev ? mq[0] : '0;
      ew   = ev && head[DW];
      n_cmp++;
      if ({out1.valid, out1.wen, occ1, in1.ready, in2.ready} !== {ev, ew, 2'(mq.size()), m_in_ready, m_in_ready}) begin
        n_err++; $display("[TB] FAIL rand_ctrl_%0d got v/w/occ/rdy1/rdy2=%b exp=%b", c,
          {out1.valid, out1.wen, occ1, in1.ready, in2.ready}, {ev, ew, 2'(mq.size()), m_in_ready, m_in_ready});
      end
      if (ev) begin
        n_cmp++;
        if (out1.data !== head[DW-1:0] || out2.data !== head[DW-1:0]) begin
          n_err++; $display("[TB] FAIL rand_data_%0d got=%h exp=%h", c, out1.data, head[DW-1:0]);
        end
      end
      n_cmp++;
      if (stall1 !== 16'(m_stall16) || stall2 !== 4'(m_stall4)) begin
        n_err++; $display("[TB] FAIL rand_stall_%0d got=%0d/%0d exp=%0d/%0d", c, stall1, stall2, m_stall16, m_stall4);
      end
    end
    flush = 1'b0;
    in1.valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain();
    out1.ready = 1'b0; in1.valid = 1'b1; in1.wen = 1'b1;
    in1.data = 128'h11; tick();
    in1.data = 128'h22; tick();
    in1.valid = 1'b0;
    n_cmp++;
    if (occ1 !== 2'd2 || stall1 === 16'd0) begin
      n_err++; $display("[TB] FAIL midrst_pre got occ=%0d stall=%0d exp occ=2 stall>0", occ1, stall1);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out1.valid, out1.wen, occ1, stall1, in1.ready} !== 21'd0 || out1.data !== '0) begin
      n_err++; $display("[TB] FAIL midrst_dut1 got=%h data=%h exp=0", {out1.valid, out1.wen, occ1, stall1, in1.ready}, out1.data);
    end
    n_cmp++;
    if ({out2.valid, out2.wen, occ2, stall2} !== 8'd0) begin
      n_err++; $display("[TB] FAIL midrst_dut2 got=%h exp=0", {out2.valid, out2.wen, occ2, stall2});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    out1.ready = 1'b1;
    tick();
    n_cmp++;
    if ({out1.valid, occ1, in1.ready} !== 4'b0001) begin
      n_err++; $display("[TB] FAIL midrst_after got v/occ/rdy=%b exp=0001", {out1.valid, occ1, in1.ready});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
